// File: rtl/alu_issue_16_pkg.sv
// Shared definitions for the ALU issue front end: function codes and FSM states.
package alu_issue_16_pkg;

  localparam logic [5:0] ALUFN_ADD    = 6'b000000;
  localparam logic [5:0] ALUFN_SUB    = 6'b000001;
  localparam logic [5:0] ALUFN_MUL_LO = 6'b000010;
  localparam logic [5:0] ALUFN_AND    = 6'b011000;
  localparam logic [5:0] ALUFN_OR     = 6'b011110;
  localparam logic [5:0] ALUFN_XOR    = 6'b010110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_16.sv
// Combinational 16-bit ALU: result plus zero/negative/signed-overflow flags.
module alu_16
  import alu_issue_16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       alufn,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             n,
  output logic             v
);

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    out = '0;
    v   = 1'b0;
    case (alufn)
      ALUFN_ADD: begin
        out = a + b;
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
      end
      ALUFN_SUB: begin
        out = a - b;
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
      end
      ALUFN_MUL_LO: out = a * b;
      ALUFN_AND:    out = a & b;
      ALUFN_OR:     out = a | b;
      ALUFN_XOR:    out = a ^ b;
      default:      out = '0;
    endcase
  end

  assign z = (out == '0);
  assign n = out[WIDTH-1];

endmodule

// File: rtl/alu_issue_16_fifo.sv
// Small synchronous request FIFO with occupancy count and full/empty flags.
module alu_req_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array is reset along with the pointers so no stale request data survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_issue_16.sv
// Request/response front end: queues ALU requests, issues them one at a time, registers results.
module alu_issue_16
  import alu_issue_16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [5:0]       req_alufn,
  input  logic             req_acc,
  input  logic             acc_clr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_z,
  output logic             rsp_n,
  output logic             rsp_v,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  localparam int REQ_W = 2*WIDTH + 7;

  logic [REQ_W-1:0]       head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop, capture, release_rsp;

  logic [WIDTH-1:0] alu_out;
  logic             alu_z, alu_n, alu_v;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [5:0]       op_fn_q, op_fn_d;
  logic [WIDTH-1:0] acc_q, acc_d, rsp_out_q, rsp_out_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_z_q, rsp_z_d, rsp_n_q, rsp_n_d, rsp_v_q, rsp_v_d;

  assign push = req_valid && req_ready;

  alu_req_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({req_acc, req_alufn, req_a, req_b}),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  alu_16 #(.WIDTH(WIDTH)) u_alu (
    .a     (op_a_q),
    .b     (op_b_q),
    .alufn (op_fn_q),
    .out   (alu_out),
    .z     (alu_z),
    .n     (alu_n),
    .v     (alu_v)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: if (rsp_valid_q && rsp_ready) state_d = fifo_empty ? ST_IDLE : ST_EXEC;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state_q)
      ST_IDLE: pop = !fifo_empty;
      ST_EXEC: capture = 1'b1;
      ST_HOLD: begin
        release_rsp = rsp_valid_q && rsp_ready;
        pop         = release_rsp && !fifo_empty;
      end
      default: ;
    endcase
  end

  // acc is already updated by the time of any pop, so chained requests see the latest result.
  always_comb begin
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_fn_d     = op_fn_q;
    acc_d       = acc_q;
    rsp_out_d   = rsp_out_q;
    rsp_z_d     = rsp_z_q;
    rsp_n_d     = rsp_n_q;
    rsp_v_d     = rsp_v_q;
    rsp_valid_d = rsp_valid_q;
    if (pop) begin
      op_a_d  = head[REQ_W-1] ? acc_q : head[WIDTH +: WIDTH];
      op_b_d  = head[0 +: WIDTH];
      op_fn_d = head[2*WIDTH +: 6];
    end
    if (capture) begin
      rsp_out_d   = alu_out;
      rsp_z_d     = alu_z;
      rsp_n_d     = alu_n;
      rsp_v_d     = alu_v;
      rsp_valid_d = 1'b1;
      acc_d       = alu_out;
    end else if (release_rsp) begin
      rsp_valid_d = 1'b0;
    end
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_fn_q     <= '0;
      acc_q       <= '0;
      rsp_out_q   <= '0;
      rsp_z_q     <= 1'b0;
      rsp_n_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_fn_q     <= op_fn_d;
      acc_q       <= acc_d;
      rsp_out_q   <= rsp_out_d;
      rsp_z_q     <= rsp_z_d;
      rsp_n_q     <= rsp_n_d;
      rsp_v_q     <= rsp_v_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = !fifo_full;
  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_n     = rsp_n_q;
  assign rsp_v     = rsp_v_q;
  assign acc       = acc_q;
  assign busy      = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_16.sv
// Directed and randomized checks of alu_issue_16 against a queue-based arithmetic model.
module tb_alu_issue_16;
  import alu_issue_16_pkg::*;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_acc, acc_clr;
  logic [15:0] req_a, req_b;
  logic [5:0]  req_alufn;
  logic        rsp_valid, rsp_ready, rsp_z, rsp_n, rsp_v, busy;
  logic [15:0] rsp_out, acc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  fn;
    logic        sel;
  } req_s;

  req_s        mq[$];
  logic [15:0] m_acc;

  alu_issue_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_alufn (req_alufn),
    .req_acc   (req_acc),
    .acc_clr   (acc_clr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_z     (rsp_z),
    .rsp_n     (rsp_n),
    .rsp_v     (rsp_v),
    .acc       (acc),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Signed-integer reference: overflow means the true result leaves the 16-bit signed range.
  function automatic logic [18:0] ref_alu(input logic [5:0] fn, input logic [15:0] a,
                                          input logic [15:0] b);
    longint r;
    logic [15:0] o;
    logic ov;
    r  = 0;
    ov = 1'b0;
    if (fn == ALUFN_ADD) begin
      r  = longint'($signed(a)) + longint'($signed(b));
      ov = (r > 32767) || (r < -32768);
    end else if (fn == ALUFN_SUB) begin
      r  = longint'($signed(a)) - longint'($signed(b));
      ov = (r > 32767) || (r < -32768);
    end else if (fn == ALUFN_MUL_LO) begin
      r = longint'(a) * longint'(b);
    end
    o = r[15:0];
    return {o, o == 16'h0, o[15], ov};
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [5:0] fn,
                      input logic sel);
    int n = 0;
    req_a = a; req_b = b; req_alufn = fn; req_acc = sel; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_acc   = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [18:0] exp);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, rsp_valid, 1);
    check(tag, {rsp_out, rsp_z, rsp_n, rsp_v}, exp);
    @(negedge clk);
  endtask

  // Called at a negedge with next-edge inputs already driven: scores handshakes of the coming edge.
  task automatic observe();
    req_s r;
    logic [18:0] e;
    if (req_valid && req_ready)
      mq.push_back('{a: req_a, b: req_b, fn: req_alufn, sel: req_acc});
    if (rsp_valid && rsp_ready) begin
      if (mq.size() == 0) begin
        check("rnd_spurious_rsp", rsp_valid, 0);
      end else begin
        r = mq.pop_front();
        e = ref_alu(r.fn, r.sel ? m_acc : r.a, r.b);
        check("rnd_rsp", {rsp_out, rsp_z, rsp_n, rsp_v}, e);
        check("rnd_acc", acc, e[18:3]);
        m_acc = e[18:3];
      end
    end
  endtask

  initial begin
    logic seen;
    int n;
    logic [5:0] fns [3];
    fns[0] = ALUFN_ADD; fns[1] = ALUFN_SUB; fns[2] = ALUFN_MUL_LO;

    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_alufn = '0;
    req_acc = 1'b0; acc_clr = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp", {rsp_out, rsp_z, rsp_n, rsp_v}, 0);
    check("rst_acc", acc, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD with exact latency: accept E0, pop E1, capture E2.
    req_a = 16'h0003; req_b = 16'h0004; req_alufn = ALUFN_ADD; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("add_e0_valid", rsp_valid, 0);
    check("add_e0_busy", busy, 1);
    @(negedge clk);
    check("add_e1_valid", rsp_valid, 0);
    @(negedge clk);
    check("add_e2_valid", rsp_valid, 1);
    check("add_e2_rsp", {rsp_out, rsp_z, rsp_n, rsp_v}, {16'h0007, 3'b000});
    check("add_e2_acc", acc, 16'h0007);
    @(negedge clk);
    check("add_e3_valid", rsp_valid, 0);
    check("add_e3_busy", busy, 0);

    send(16'h0005, 16'h0005, ALUFN_SUB, 1'b0);
    expect_rsp("sub_zero", {16'h0000, 3'b100});
    send(16'h7FFF, 16'h0001, ALUFN_ADD, 1'b0);
    expect_rsp("add_ovf", {16'h8000, 3'b011});

    send(16'h0010, 16'h0001, ALUFN_ADD, 1'b0);
    expect_rsp("acc_base", {16'h0011, 3'b000});
    send(16'hDEAD, 16'h0002, ALUFN_ADD, 1'b1);
    expect_rsp("acc_chain", {16'h0013, 3'b000});
    check("acc_chain_acc", acc, 16'h0013);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    check("acc_clr", acc, 16'h0000);

    // Back-pressure: the first response stalls while two more requests fill the FIFO.
    rsp_ready = 1'b0;
    send(16'h0012, 16'h0003, ALUFN_MUL_LO, 1'b0);
    send(16'h0001, 16'h0001, ALUFN_ADD, 1'b0);
    send(16'h0002, 16'h0002, ALUFN_ADD, 1'b0);
    check("bp_req_ready_low", req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      check("bp_hold", {rsp_valid, rsp_out, rsp_z, rsp_n, rsp_v}, {1'b1, 16'h0036, 3'b000});
      @(negedge clk);
    end
    check("bp_still_full", req_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop1_valid", rsp_valid, 0);
    check("bp_pop1_ready", req_ready, 1);
    @(negedge clk);
    check("bp_rsp2", {rsp_valid, rsp_out}, {1'b1, 16'h0002});
    @(negedge clk);
    check("bp_pop2_valid", rsp_valid, 0);
    @(negedge clk);
    check("bp_rsp3", {rsp_valid, rsp_out}, {1'b1, 16'h0004});
    @(negedge clk);
    check("bp_idle_busy", busy, 0);

    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    check("rnd_acc_start", acc, 0);
    m_acc = 16'h0000;

    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_a     = 16'($urandom);
      req_b     = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      req_alufn = fns[$urandom_range(0, 2)];
      req_acc   = ($urandom_range(0, 2) == 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      observe();
      @(negedge clk);
    end
    req_valid = 1'b0;
    req_acc   = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while ((mq.size() != 0 || rsp_valid) && n < 200) begin
      observe();
      @(negedge clk);
      n++;
    end
    check("rnd_drained", mq.size(), 0);
    check("rnd_idle_busy", busy, 0);

    // Reset while the first request is in EXEC and a second is queued.
    send(16'h1111, 16'h2222, ALUFN_ADD, 1'b0);
    send(16'h3333, 16'h4444, ALUFN_ADD, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_req_ready", req_ready, 1);
    check("mrst_rsp", {rsp_out, rsp_z, rsp_n, rsp_v}, 0);
    check("mrst_acc", acc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("mrst_no_stale_rsp", seen, 0);
    check("mrst_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
